tile_scan_ctrl: RTL and testbench
=================================

// Module: tile_scan_ctrl
// PURPOSE
// Sequences the pixel-address walk over a frame in TILE x TILE blocks, for the block transform/entropy stages.
// Raster order inside each tile; tiles in raster order across the frame.
// Emits one frame-buffer read address per valid/ready handshake, with tile/frame boundary flags.
// A start/done pair frames each pass. Sits between the frame buffer and the block pipeline front end.
// PARAMETERS
// IMG_W   64  frame width in pixels; multiple of TILE
// IMG_H   64  frame height in pixels; multiple of TILE
// TILE    8   tile edge in pixels; power of 2, >= 2
// ADDR_W  12  address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
// clk          in   1       clock, all state on rising edge
// rst          in   1       synchronous, active-high reset
// start        in   1       begin a frame pass; sampled only in IDLE
// abort        in   1       cancel pass; sampled in SCAN
// addr_ready   in   1       downstream accepts addr this cycle
// addr_valid   out  1       addr/flags valid
// addr         out  ADDR_W  linear pixel address (y*IMG_W + x)
// tile_first   out  1       addr is pixel (0,0) of its tile
// tile_last    out  1       addr is pixel (TILE-1,TILE-1) of its tile
// frame_last   out  1       addr is final pixel of frame
// busy         out  1       high in SCAN and DONE
// done         out  1       one-cycle pulse after final handshake
// BEHAVIOUR
// - Reset: state=IDLE; all counters 0; addr_valid, addr, flags, busy, done all 0.
// - Counters: px, py (within tile, 0..TILE-1); tx (0..IMG_W/TILE-1); ty (0..IMG_H/TILE-1).
//   - Advance only on handshake (addr_valid & addr_ready).
//   - Order: px, then py, then tx, then ty. Each wraps to 0 and carries into the next.
// - addr = (ty*TILE+py)*IMG_W + tx*TILE + px. Computed in ADDR_W bits; no overflow given the parameter rule.
// - Outputs are registered: addr/flags reflect the current counter values and carry no combinational path from inputs.
// - FSM states:
//   - IDLE: addr_valid=0. start -> SCAN; counters cleared the same edge.
//   - SCAN: addr_valid=1, so the first address appears the cycle after start is sampled.
//     - addr and flags are held stable while addr_valid & !addr_ready.
//     - Handshake with frame_last=1 -> DONE.
//     - abort=1 -> IDLE next cycle, with no done and counters cleared. abort wins over a same-cycle handshake.
//     - start is ignored in SCAN.
//   - DONE: addr_valid=0, done=1 for exactly one cycle -> IDLE.
//     - A start arriving in DONE is ignored. A new start is accepted from IDLE, the cycle after the done pulse.
// - Throughput: one address per cycle while addr_ready=1. No bubbles at tile or row wrap.
// - Flags: tile_first = (px==0 & py==0); tile_last = (px==TILE-1 & py==TILE-1);
//   frame_last = tile_last & tx==IMG_W/TILE-1 & ty==IMG_H/TILE-1.
// - rst mid-pass: returns to reset state next edge, unconditionally, with no done.
// - busy = (state != IDLE).
// STRUCTURE
// - Package tile_scan_pkg:
//   - state enum {IDLE, SCAN, DONE}
//   - localparams TILES_X = IMG_W/TILE and TILES_Y = IMG_H/TILE
//   - clog2-derived counter widths
// - Sub-module wrap_counter #(WIDTH, MAX): ports en, clear, count, wrap (combinational, = en & count==MAX).
//   Instanced 4x (px, py, tx, ty); each en is the wrap of the previous stage.
// - The address multiply reduces to shifts because TILE is a power of 2. IMG_W uses a constant multiply.
// TESTING (IMG_W=16, IMG_H=8, TILE=4, ADDR_W=7; 8 tiles, 128 pixels)
// - Reset then idle 5 cycles -> addr_valid=0, busy=0, done=0, addr=0.
// - start pulse, addr_ready=1 -> addr_valid rises next cycle.
//   - Addrs 0,1,2,3,16,17,18,19,32,...,51 then 4; tile_first on 0 and 4; tile_last on 51.
//   - Address 64 at handshake 65 (tile 4 start); frame_last only on 127.
//   - done pulses once, 1 cycle after the 128th handshake; total 128 handshakes.
// - addr_ready toggled pseudo-randomly -> addr/flags stable while stalled; address sequence identical to the prior test.
// - abort asserted at handshake 40 -> IDLE next cycle, no done; a new start restarts at addr 0.
// - start held high through SCAN and DONE -> no restart mid-pass; the next pass begins from IDLE after the done pulse.
// - rst asserted during a stall at addr 67 -> all outputs 0 next cycle; a subsequent start begins at 0.

Source files
------------

// File: rtl/tile_scan_pkg.sv
// Shared types and helpers for the tile scan controller.
package tile_scan_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    localparam int unsigned DEF_IMG_W  = 64;
    localparam int unsigned DEF_IMG_H  = 64;
    localparam int unsigned DEF_TILE   = 8;
    localparam int unsigned DEF_ADDR_W = 12;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter; o_wrap flags the enabled step that returns it to zero.
module wrap_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MAX   = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == MaxVal);
    assign o_wrap   = i_en & w_at_max;
    assign o_count  = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_max ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/tile_scan_ctrl.sv
// Walks a frame tile by tile (raster inside and across tiles), one read address per handshake.
module tile_scan_ctrl
    import tile_scan_pkg::*;
#(
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H,
    parameter int unsigned TILE   = DEF_TILE,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_addr_ready,
    output logic              o_addr_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_tile_first,
    output logic              o_tile_last,
    output logic              o_frame_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned TilesX = IMG_W / TILE;
    localparam int unsigned TilesY = IMG_H / TILE;
    localparam int unsigned PW     = cnt_width(TILE);
    localparam int unsigned TxW    = cnt_width(TilesX);
    localparam int unsigned TyW    = cnt_width(TilesY);

    localparam logic [PW-1:0]  PMax  = PW'(TILE - 1);
    localparam logic [TxW-1:0] TxMax = TxW'(TilesX - 1);
    localparam logic [TyW-1:0] TyMax = TyW'(TilesY - 1);

    state_e r_state, w_state_next;

    logic [PW-1:0]  w_px, w_py;
    logic [TxW-1:0] w_tx;
    logic [TyW-1:0] w_ty;
    logic           w_px_wrap, w_py_wrap, w_tx_wrap, w_ty_wrap;
    logic           w_scan, w_hs, w_clear, w_tile_last;
    logic [ADDR_W-1:0] w_row, w_col;

    assign w_scan  = (r_state == StScan);
    // Abort takes priority, so a same-cycle handshake never advances the walk.
    assign w_hs    = w_scan & i_addr_ready & ~i_abort;
    assign w_clear = ((r_state == StIdle) & i_start) | (w_scan & i_abort);

    wrap_counter #(.WIDTH(PW), .MAX(TILE - 1)) u_px (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_hs),
        .i_clear (w_clear),
        .o_count (w_px),
        .o_wrap  (w_px_wrap)
    );

    wrap_counter #(.WIDTH(PW), .MAX(TILE - 1)) u_py (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_px_wrap),
        .i_clear (w_clear),
        .o_count (w_py),
        .o_wrap  (w_py_wrap)
    );

    wrap_counter #(.WIDTH(TxW), .MAX(TilesX - 1)) u_tx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_py_wrap),
        .i_clear (w_clear),
        .o_count (w_tx),
        .o_wrap  (w_tx_wrap)
    );

    wrap_counter #(.WIDTH(TyW), .MAX(TilesY - 1)) u_ty (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_tx_wrap),
        .i_clear (w_clear),
        .o_count (w_ty),
        .o_wrap  (w_ty_wrap)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The final-pixel handshake is exactly the one that wraps the last counter.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_start) w_state_next = StScan;
            StScan: begin
                if (i_abort) begin
                    w_state_next = StIdle;
                end else if (w_ty_wrap) begin
                    w_state_next = StDone;
                end
            end
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // TILE is a power of two, so ty*TILE+py and tx*TILE+px are plain concatenations.
    assign w_row = ADDR_W'({w_ty, w_py});
    assign w_col = ADDR_W'({w_tx, w_px});

    assign w_tile_last  = (w_px == PMax) & (w_py == PMax);
    assign o_addr       = w_row * ADDR_W'(IMG_W) + w_col;
    assign o_addr_valid = w_scan;
    assign o_tile_first = w_scan & (w_px == '0) & (w_py == '0);
    assign o_tile_last  = w_scan & w_tile_last;
    assign o_frame_last = w_scan & w_tile_last & (w_tx == TxMax) & (w_ty == TyMax);
    assign o_busy       = (r_state != StIdle);
    assign o_done       = (r_state == StDone);

endmodule

// File: tb/tb_tile_scan_ctrl.sv
// Randomised scenario bench for tile_scan_ctrl against a loop-built address/flag table.
module tb_tile_scan_ctrl;

    localparam int unsigned IMG_W  = 16;
    localparam int unsigned IMG_H  = 8;
    localparam int unsigned TILE   = 4;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned NPIX   = IMG_W * IMG_H;
    localparam int unsigned TX     = IMG_W / TILE;
    localparam int unsigned TY     = IMG_H / TILE;

    logic clk = 1'b0;
    logic rst, start, abort, ready;
    logic valid, tf, tl, fl, busy, done;
    logic [ADDR_W-1:0] addr;

    logic [ADDR_W-1:0] exp_addr [NPIX];
    bit exp_tf [NPIX];
    bit exp_tl [NPIX];
    bit exp_fl [NPIX];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tile_scan_ctrl #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .TILE   (TILE),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_addr_ready (ready),
        .o_addr_valid (valid),
        .o_addr       (addr),
        .o_tile_first (tf),
        .o_tile_last  (tl),
        .o_frame_last (fl),
        .o_busy       (busy),
        .o_done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_model();
        int k = 0;
        for (int ty = 0; ty < int'(TY); ty++)
            for (int tx = 0; tx < int'(TX); tx++)
                for (int py = 0; py < int'(TILE); py++)
                    for (int px = 0; px < int'(TILE); px++) begin
                        exp_addr[k] = ADDR_W'((ty * TILE + py) * IMG_W + tx * TILE + px);
                        exp_tf[k]   = (px == 0) && (py == 0);
                        exp_tl[k]   = (px == TILE - 1) && (py == TILE - 1);
                        exp_fl[k]   = exp_tl[k] && (tx == TX - 1) && (ty == TY - 1);
                        k++;
                    end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        tests++;
        if ({valid, busy, done, tf, tl, fl} !== 6'b0 || addr !== '0) begin
            fails++;
            $display("FAIL reset: valid=%b busy=%b done=%b tf=%b tl=%b fl=%b addr=%0d, want all 0",
                     valid, busy, done, tf, tl, fl, addr);
        end
    endtask

    // Full pass with ready held high or randomised; checks order, flags, stall stability, done.
    task automatic test_pass(input bit rnd, input bit hold_start);
        int k = 0, cyc = 0, dones = 0;
        bit stalled = 1'b0;
        logic [ADDR_W+2:0] held;
        ready = 1'b1; start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        tests++;
        if (valid !== 1'b1) begin
            fails++;
            $display("FAIL first_valid: valid=%b, want 1", valid);
        end
        while (k < int'(NPIX) && cyc < 2000) begin
            if (done) dones++;
            if (valid) begin
                tests++;
                if (addr !== exp_addr[k] || tf !== exp_tf[k] || tl !== exp_tl[k] ||
                    fl !== exp_fl[k]) begin
                    fails++;
                    $display("FAIL seq[%0d]: addr=%0d tf=%b tl=%b fl=%b, want addr=%0d tf=%b tl=%b fl=%b",
                             k, addr, tf, tl, fl, exp_addr[k], exp_tf[k], exp_tl[k], exp_fl[k]);
                end
                if (stalled) begin
                    tests++;
                    if ({addr, tf, tl, fl} !== held) begin
                        fails++;
                        $display("FAIL stall_hold: got %h, want %h", {addr, tf, tl, fl}, held);
                    end
                end
            end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = valid && !ready;
            held = {addr, tf, tl, fl};
            if (valid && ready) k++;
            tick();
            cyc++;
        end
        tests++;
        if (k != int'(NPIX) || dones != 0) begin
            fails++;
            $display("FAIL pass_count: handshakes=%0d early_done=%0d, want %0d and 0", k, dones, NPIX);
        end
        tests++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL done_pulse: done=%b valid=%b busy=%b, want 1 0 1", done, valid, busy);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL after_done: done=%b busy=%b valid=%b, want 0 0 0", done, busy, valid);
        end
        if (hold_start) begin
            tick();
            tests++;
            if (valid !== 1'b1 || addr !== '0 || tf !== 1'b1) begin
                fails++;
                $display("FAIL restart_from_idle: valid=%b addr=%0d tf=%b, want 1 0 1", valid, addr, tf);
            end
            start = 1'b0; abort = 1'b1;
            tick();
            abort = 1'b0;
            tests++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_cleanup: valid=%b busy=%b, want 0 0", valid, busy);
            end
        end
    endtask

    task automatic test_abort();
        int k = 0, dones = 0;
        ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        while (k < 39) begin
            if (valid) k++;
            tick();
        end
        tests++;
        if (addr !== exp_addr[39]) begin
            fails++;
            $display("FAIL abort_point: addr=%0d, want %0d", addr, exp_addr[39]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++;
        if (valid !== 1'b0 || busy !== 1'b0 || addr !== '0) begin
            fails++;
            $display("FAIL abort_idle: valid=%b busy=%b addr=%0d, want 0 0 0", valid, busy, addr);
        end
        repeat (5) begin
            if (done) dones++;
            tick();
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL abort_no_done: done pulses=%0d, want 0", dones);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (valid !== 1'b1 || addr !== exp_addr[0] || tf !== 1'b1) begin
            fails++;
            $display("FAIL abort_restart: valid=%b addr=%0d tf=%b, want 1 0 1", valid, addr, tf);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_rst_mid();
        int cyc = 0;
        ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        while (!(valid && addr == ADDR_W'(67)) && cyc < 500) begin
            tick();
            cyc++;
        end
        ready = 1'b0;
        repeat (3) tick();
        tests++;
        if (valid !== 1'b1 || addr !== ADDR_W'(67)) begin
            fails++;
            $display("FAIL rst_stall: valid=%b addr=%0d, want 1 67", valid, addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({valid, busy, done, tf, tl, fl} !== 6'b0 || addr !== '0) begin
            fails++;
            $display("FAIL rst_mid: valid=%b busy=%b done=%b flags=%b%b%b addr=%0d, want all 0",
                     valid, busy, done, tf, tl, fl, addr);
        end
        ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (valid !== 1'b1 || addr !== '0 || tf !== 1'b1) begin
            fails++;
            $display("FAIL rst_restart: valid=%b addr=%0d tf=%b, want 1 0 1", valid, addr, tf);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        build_model();
        test_reset();
        test_pass(1'b0, 1'b0);
        test_pass(1'b1, 1'b0);
        test_abort();
        test_pass(1'b0, 1'b1);
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
